// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// Module : mole_pkg
// Brief  : Shared types and constants for the whack-a-mole round controller:
//          FSM state encoding, LFSR seed/taps and the score width.
// Rev    : 1.0  initial release
// ============================================================================
package mole_pkg;

  // Game sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam logic [15:0] c_lfsr_taps = 16'hB400;
  localparam int unsigned c_score_w   = 8;

  // One step of a right-shifting Galois LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? c_lfsr_taps : 16'h0000);
  endfunction

endpackage : mole_pkg
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// ============================================================================
// Module : mole_lfsr
// Brief  : Free-running 16-bit Galois LFSR used to pick the next mole.
//          Advances every clock from reset.
// Rev    : 1.0  initial release
// ============================================================================
module mole_lfsr
  import mole_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value of the shift register
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // Shift register, seeded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= c_lfsr_seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule : mole_lfsr
`default_nettype wire

// File: rtl/mole_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mole_round_ctrl
// Brief  : Whack-a-mole game sequencer. Lights one mole at a time for a
//          fixed window, scores hits and misses, counts rounds.
//          Optional build macro MOLE_MISS_PENALTY_EN: a wrong key while a
//          mole is lit costs one point (saturating at zero).
// Rev    : 1.0  initial release
// ============================================================================
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned N_MOLES    = 8,
  parameter int unsigned SHOW_TICKS = 25000000,
  parameter int unsigned GAP_TICKS  = 10000000,
  parameter int unsigned ROUNDS     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_MOLES-1:0]   key_pulse,
  output logic [N_MOLES-1:0]   mole_led,
  output logic [c_score_w-1:0] score,
  output logic [7:0]           round_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  // Timer counts down from (ticks-1) to 0, so it only needs to hold max-1
  localparam int unsigned c_tmax = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned c_tw   = $clog2(c_tmax);
  localparam int unsigned c_iw   = $clog2(N_MOLES);

  localparam logic [c_tw-1:0]      c_gap_load  = c_tw'(GAP_TICKS - 1);
  localparam logic [c_tw-1:0]      c_show_load = c_tw'(SHOW_TICKS - 1);
  localparam logic [c_tw-1:0]      c_t_one     = c_tw'(1);
  localparam logic [7:0]           c_rounds    = 8'(ROUNDS);
  localparam logic [7:0]           c_n8        = 8'(N_MOLES);
  localparam logic [c_score_w-1:0] c_score_max = {c_score_w{1'b1}};
  localparam logic [c_score_w-1:0] c_score_one = c_score_w'(1);
  localparam logic [N_MOLES-1:0]   c_led_one   = N_MOLES'(1);

  state_e               state_q, state_d;
  logic [c_tw-1:0]      timer_q, timer_d;
  logic [c_iw-1:0]      idx_q, idx_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [N_MOLES-1:0]   mole_led_q, mole_led_d;
  logic [c_score_w-1:0] score_q, score_d;
  logic [7:0]           round_q, round_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic [15:0]          w_lfsr;
  logic                 w_unused_lfsr_hi;
  logic [7:0]           w_raw8;
  logic [7:0]           w_pick8;
  logic [c_iw-1:0]      w_idx;
  logic                 w_hit;

  mole_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  // Only the low byte feeds the mole choice
  assign w_unused_lfsr_hi = ^w_lfsr[15:8];

  // Pick the next mole; bump by one (wrapping) so it never repeats the last one
  always_comb begin
    w_raw8  = w_lfsr[7:0] % c_n8;
    w_pick8 = w_raw8;
    if (prev_valid_q && (w_raw8 == {{(8 - c_iw){1'b0}}, idx_q})) begin
      w_pick8 = ((w_raw8 + 8'd1) == c_n8) ? 8'd0 : (w_raw8 + 8'd1);
    end
    w_idx = w_pick8[c_iw-1:0];
  end

  assign w_hit = key_pulse[idx_q];

`ifdef MOLE_MISS_PENALTY_EN
  logic [N_MOLES-1:0] w_mask;
  logic               w_wrong;
  assign w_mask  = c_led_one << idx_q;
  assign w_wrong = |(key_pulse & ~w_mask);
`endif

  // Game FSM: next state, timer, scoring and output values
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    prev_valid_d = prev_valid_q;
    mole_led_d   = mole_led_q;
    score_d      = score_q;
    round_d      = round_q;
    busy_d       = busy_q;
    done_d       = done_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_GAP;
          timer_d      = c_gap_load;
          score_d      = '0;
          round_d      = '0;
          done_d       = 1'b0;
          busy_d       = 1'b1;
          prev_valid_d = 1'b0;
          mole_led_d   = '0;
        end
      end

      ST_GAP: begin
        if (timer_q == '0) begin
          state_d      = ST_SHOW;
          timer_d      = c_show_load;
          idx_d        = w_idx;
          prev_valid_d = 1'b1;
          mole_led_d   = c_led_one << w_idx;
          round_d      = round_q + 8'd1;
        end else begin
          timer_d = timer_q - c_t_one;
        end
      end

      ST_SHOW: begin
        // A hit on the final cycle takes priority over the timeout
        if (w_hit || (timer_q == '0)) begin
          mole_led_d = '0;
          if (w_hit) begin
            hit_d = 1'b1;
            if (score_q != c_score_max) begin
              score_d = score_q + c_score_one;
            end
          end else begin
            miss_d = 1'b1;
          end
          if (round_q == c_rounds) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
            timer_d = c_gap_load;
          end
        end else begin
          timer_d = timer_q - c_t_one;
`ifdef MOLE_MISS_PENALTY_EN
          if (w_wrong && (score_q != '0)) begin
            score_d = score_q - c_score_one;
          end
`else
          // Wrong keys are ignored while a mole is lit
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any game in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      idx_q        <= '0;
      prev_valid_q <= 1'b0;
      mole_led_q   <= '0;
      score_q      <= '0;
      round_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      prev_valid_q <= prev_valid_d;
      mole_led_q   <= mole_led_d;
      score_q      <= score_d;
      round_q      <= round_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign mole_led   = mole_led_q;
  assign score      = score_q;
  assign round_cnt  = round_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule : mole_round_ctrl
`default_nettype wire
